// File: rtl/node_mem_arbiter.sv
// Round-robin arbiter sharing the single-port node-information bank between NREQ requesters.
// Optional post-reset clear sweep is enabled by defining NODE_MEM_CLEAR_EN.
module node_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 6,
    parameter int WORD_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NREQ-1:0]            i_req,
    input  logic [NREQ-1:0]            i_we,
    input  logic [NREQ*ADDR_W-1:0]     i_index,
    input  logic [NREQ*WORD_W-1:0]     i_wdata,
    output logic [NREQ-1:0]            o_gnt,
    output logic                       o_rd_valid,
    output logic [WORD_W-1:0]          o_rd_data,
    output logic [$clog2(NREQ)-1:0]    o_rd_id,
    output logic                       o_busy,
    output logic                       o_mem_wr_en,
    output logic [ADDR_W-1:0]          o_mem_index,
    output logic [WORD_W-1:0]          o_mem_data_in,
    input  logic [WORD_W-1:0]          i_mem_data_out
);

    localparam int          ID_W   = $clog2(NREQ);
    localparam int unsigned NREQ_U = NREQ;

    if (DEPTH != (1 << ADDR_W) || NREQ < 2 || NREQ > 8) begin : g_param_check
        $error("node_mem_arbiter: DEPTH must be 2**ADDR_W and NREQ within 2..8");
    end

`ifdef NODE_MEM_CLEAR_EN
    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACCESS} state_t;
    localparam state_t ST_RESET = ST_CLEAR;
`else
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t              r_state;
    logic [NREQ-1:0]     r_gnt;
    logic                r_rd_valid;
    logic [WORD_W-1:0]   r_rd_data;
    logic [ID_W-1:0]     r_rd_id;
    logic                r_mem_wr_en;
    logic [ADDR_W-1:0]   r_mem_index;
    logic [WORD_W-1:0]   r_mem_data_in;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_win;
    logic                r_rd_pend;
    logic [ID_W-1:0]     r_pend_id;
`ifdef NODE_MEM_CLEAR_EN
    logic                r_busy;
    logic [ADDR_W-1:0]   r_cnt;
`endif

    logic                w_any;
    logic [ID_W-1:0]     w_win;
    logic [NREQ-1:0]     w_onehot;
    logic                w_we;
    logic [ADDR_W-1:0]   w_idx;
    logic [WORD_W-1:0]   w_dat;

    // First requester found scanning upward from r_rr_ptr, wrapping at NREQ.
    always_comb begin
        int unsigned v_pos;
        v_pos    = '0;
        w_any    = 1'b0;
        w_win    = '0;
        w_onehot = '0;
        w_we     = 1'b0;
        w_idx    = '0;
        w_dat    = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            v_pos = 32'(r_rr_ptr) + k;
            if (v_pos >= NREQ_U) v_pos = v_pos - NREQ_U;
            if (!w_any && i_req[v_pos]) begin
                w_any           = 1'b1;
                w_win           = v_pos[ID_W-1:0];
                w_onehot[v_pos] = 1'b1;
                w_we            = i_we[v_pos];
                w_idx           = i_index[v_pos*ADDR_W +: ADDR_W];
                w_dat           = i_wdata[v_pos*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RESET;
            r_gnt         <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_id       <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_index   <= '0;
            r_mem_data_in <= '0;
            r_rr_ptr      <= '0;
            r_win         <= '0;
            r_rd_pend     <= 1'b0;
            r_pend_id     <= '0;
`ifdef NODE_MEM_CLEAR_EN
            r_busy        <= 1'b1;
            r_cnt         <= '0;
`endif
        end else begin
            // Bank output is valid one cycle after the read access; capture it then.
            r_rd_valid <= r_rd_pend;
            r_rd_pend  <= 1'b0;
            if (r_rd_pend) begin
                r_rd_data <= i_mem_data_out;
                r_rd_id   <= r_pend_id;
            end
            case (r_state)
`ifdef NODE_MEM_CLEAR_EN
                ST_CLEAR: begin
                    r_mem_wr_en   <= 1'b1;
                    r_mem_index   <= r_cnt;
                    r_mem_data_in <= '0;
                    r_cnt         <= r_cnt + ADDR_W'(1);
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt         <= w_onehot;
                        r_mem_wr_en   <= w_we;
                        r_mem_index   <= w_idx;
                        r_mem_data_in <= w_dat;
                        r_win         <= w_win;
                        r_state       <= ST_ACCESS;
                    end else begin
                        r_mem_wr_en <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_gnt       <= '0;
                    r_mem_wr_en <= 1'b0;
                    r_rd_pend   <= ~r_mem_wr_en;
                    r_pend_id   <= r_win;
                    if (32'(r_win) + 32'd1 >= NREQ_U) r_rr_ptr <= '0;
                    else                              r_rr_ptr <= r_win + ID_W'(1);
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_RESET;
            endcase
        end
    end

    assign o_gnt         = r_gnt;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_rd_id       = r_rd_id;
    assign o_mem_wr_en   = r_mem_wr_en;
    assign o_mem_index   = r_mem_index;
    assign o_mem_data_in = r_mem_data_in;
`ifdef NODE_MEM_CLEAR_EN
    assign o_busy        = r_busy;
`else
    assign o_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_node_mem_arbiter.sv
// Scoreboard bench for node_mem_arbiter: a round-level model predicts grant order, bank
// accesses and read returns; a negedge monitor compares against the DUT.
module tb_node_mem_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 6;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 64;
    localparam int ID_W   = $clog2(NREQ);
`ifdef NODE_MEM_CLEAR_EN
    localparam int BUSY_RST = 1;
`else
    localparam int BUSY_RST = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         i_req = '0;
    logic [NREQ-1:0]         i_we = '0;
    logic [NREQ*ADDR_W-1:0]  i_index = '0;
    logic [NREQ*WORD_W-1:0]  i_wdata = '0;
    logic [NREQ-1:0]         o_gnt;
    logic                    o_rd_valid;
    logic [WORD_W-1:0]       o_rd_data;
    logic [ID_W-1:0]         o_rd_id;
    logic                    o_busy;
    logic                    o_mem_wr_en;
    logic [ADDR_W-1:0]       o_mem_index;
    logic [WORD_W-1:0]       o_mem_data_in;
    logic [WORD_W-1:0]       mem_dout = '0;
    logic [WORD_W-1:0]       env_mem [DEPTH];

    node_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we), .i_index(i_index),
        .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_rd_id(o_rd_id), .o_busy(o_busy), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_index(o_mem_index), .o_mem_data_in(o_mem_data_in), .i_mem_data_out(mem_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous bank standing in for memorybankNode.
    always @(posedge clk) begin
        if (o_mem_wr_en) env_mem[o_mem_index] <= o_mem_data_in;
        mem_dout <= env_mem[o_mem_index];
    end

    typedef struct { int id; bit we; int idx; int dat; int cyc; } gexp_t;
    typedef struct { int id; int dat; int cyc; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    mem_m [DEPTH];
    int    rr_m = 0;
    bit    sweeping = 1'b0;
    bit    s_we  [NREQ];
    int    s_idx [NREQ];
    int    s_dat [NREQ];
    gexp_t m_g;
    rexp_t m_r;
    logic [NREQ-1:0] m_oh;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_gnt != '0) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL gnt_unexpected: got gnt=%b required none (cyc %0d)", o_gnt, cyc);
            end else begin
                m_g = gq.pop_front();
                m_oh = '0;
                m_oh[m_g.id] = 1'b1;
                if (o_gnt != m_oh || o_mem_wr_en != m_g.we || int'(o_mem_index) != m_g.idx ||
                    (m_g.we && int'(o_mem_data_in) != m_g.dat) || cyc != m_g.cyc) begin
                    bad++;
                    $display("FAIL grant: got gnt=%b wr=%b idx=%0d din=%h cyc=%0d required gnt=%b wr=%b idx=%0d din=%h cyc=%0d",
                             o_gnt, o_mem_wr_en, o_mem_index, o_mem_data_in, cyc,
                             m_oh, m_g.we, m_g.idx, m_g.dat, m_g.cyc);
                end
            end
        end else if (!sweeping) begin
            total++;
            if (o_mem_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL idle_wr_en: got %b required 0 (cyc %0d)", o_mem_wr_en, cyc);
            end
        end
        if (!sweeping) begin
            total++;
            if (o_busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_idle: got %b required 0 (cyc %0d)", o_busy, cyc);
            end
        end
        if (o_rd_valid === 1'b1) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got rd_id=%0d data=%h required no rd_valid (cyc %0d)",
                         o_rd_id, o_rd_data, cyc);
            end else begin
                m_r = rq.pop_front();
                if (int'(o_rd_id) != m_r.id || int'(o_rd_data) != m_r.dat || cyc != m_r.cyc) begin
                    bad++;
                    $display("FAIL read: got id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                             o_rd_id, o_rd_data, cyc, m_r.id, m_r.dat, m_r.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
        end
    endtask

`ifdef NODE_MEM_CLEAR_EN
    task automatic sweep_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("sweep_wr_en", int'(o_mem_wr_en), 1);
            check("sweep_index", int'(o_mem_index), k);
            check("sweep_data",  int'(o_mem_data_in), 0);
            check("sweep_busy",  int'(o_busy), (k == DEPTH - 1) ? 0 : 1);
            check("sweep_gnt",   int'(o_gnt), 0);
        end
        if (n == DEPTH) sweeping = 1'b0;
    endtask
`endif

    // Caller positions time; rst is taken at the next posedge.
    task automatic do_reset(input int hold, input int sweep_n);
        rst = 1'b1;
        i_req = '0;
        gq.delete();
        rq.delete();
        rr_m = 0;
`ifdef NODE_MEM_CLEAR_EN
        sweeping = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rst_gnt",      int'(o_gnt), 0);
            check("rst_rd_valid", int'(o_rd_valid), 0);
            check("rst_rd_data",  int'(o_rd_data), 0);
            check("rst_rd_id",    int'(o_rd_id), 0);
            check("rst_wr_en",    int'(o_mem_wr_en), 0);
            check("rst_index",    int'(o_mem_index), 0);
            check("rst_data_in",  int'(o_mem_data_in), 0);
            check("rst_busy",     int'(o_busy), BUSY_RST);
        end
        #1 rst = 1'b0;
`ifdef NODE_MEM_CLEAR_EN
        sweep_check(sweep_n);
`else
        if (sweep_n < 0) $display("sweep length %0d", sweep_n);
`endif
    endtask

    task automatic run_round(input logic [NREQ-1:0] mask);
        int c, j, id, last, waited;
        gexp_t g;
        rexp_t r;
        @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            i_we[i] = s_we[i];
            i_index[i*ADDR_W +: ADDR_W] = ADDR_W'(s_idx[i]);
            i_wdata[i*WORD_W +: WORD_W] = WORD_W'(s_dat[i]);
        end
        i_req = mask;
        c = cyc;
        j = 0;
        last = rr_m;
        for (int k = 0; k < NREQ; k++) begin
            id = (rr_m + k) % NREQ;
            if (mask[id]) begin
                g.id = id; g.we = s_we[id]; g.idx = s_idx[id]; g.dat = s_dat[id];
                g.cyc = c + 1 + 2 * j;
                gq.push_back(g);
                if (s_we[id]) mem_m[s_idx[id]] = s_dat[id];
                else begin
                    r.id = id; r.dat = mem_m[s_idx[id]]; r.cyc = c + 3 + 2 * j;
                    rq.push_back(r);
                end
                last = id;
                j++;
            end
        end
        rr_m = (last + 1) % NREQ;
        waited = 0;
        while ((i_req != '0 || rq.size() != 0) && waited < 4 * NREQ + 10) begin
            @(negedge clk);
            #1;
            waited++;
            for (int i = 0; i < NREQ; i++) if (o_gnt[i]) i_req[i] = 1'b0;
        end
        total++;
        if (i_req != '0 || rq.size() != 0) begin
            bad++;
            $display("FAIL round_timeout: got req left=%b reads left=%0d required 0", i_req, rq.size());
            i_req = '0;
            gq.delete();
            rq.delete();
        end
    endtask

    task automatic single(input int id, input bit we, input int idx, input int dat);
        s_we[id] = we; s_idx[id] = idx; s_dat[id] = dat;
        run_round(NREQ'(1) << id);
    endtask

    task automatic reset_during_read(input int id, input int idx);
        gexp_t g;
        bit seen;
        @(negedge clk);
        #1;
        i_we[id] = 1'b0;
        i_index[id*ADDR_W +: ADDR_W] = ADDR_W'(idx);
        i_req = NREQ'(1) << id;
        g.id = id; g.we = 1'b0; g.idx = idx; g.dat = 0; g.cyc = cyc + 1;
        gq.push_back(g);
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            #1;
            if (o_gnt[id]) seen = 1'b1;
        end
        check("rst_read_gnt_seen", int'(seen), 1);
        do_reset(2, DEPTH);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = WORD_W'($urandom);
            mem_m[i] = int'(env_mem[i]);
        end
        for (int i = 0; i < NREQ; i++) begin
            s_we[i] = 1'b0; s_idx[i] = 0; s_dat[i] = 0;
        end
        @(negedge clk);
        #1;
        do_reset(3, DEPTH);
`ifdef NODE_MEM_CLEAR_EN
        @(negedge clk);
        #1;
        do_reset(1, 20);
        @(negedge clk);
        #1;
        do_reset(2, DEPTH);
`endif
        // write then read back through requester 0
        single(0, 1'b1, 2, 15);
        single(0, 1'b0, 2, 0);
        // all requesters at once from rr_ptr=1, then from rr_ptr=0
        for (int i = 0; i < NREQ; i++) begin s_we[i] = 1'b0; s_idx[i] = 10 + i; end
        run_round('1);
        single(2, 1'b0, 5, 0);
        run_round('1);
        // cross-requester write/read at the top index
        single(2, 1'b1, 63, 16'hBEEF);
        single(1, 1'b0, 63, 0);
        reset_during_read(1, 63);
        // contents across reset (cleared only when the sweep is built in)
        single(0, 1'b1, 0, 3);
        @(negedge clk);
        #1;
        do_reset(2, DEPTH);
        single(0, 1'b0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                s_we[i]  = 1'($urandom);
                s_idx[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                       : int'($urandom_range(0, 7));
                s_dat[i] = int'($urandom_range(0, 65535));
            end
            run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("grants_left", gq.size(), 0);
        check("reads_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
